term_ctrl: RTL and testbench

TERM_CTRL -- requirements
Module: term_ctrl

---
 rtl/term_pkg.sv | 33 +++
 rtl/term_ctrl_vram_mux.sv | 33 +++
 rtl/term_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_term_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// ============================================================================
// Module   : term_pkg
// Brief    : Shared encodings and field widths for the text terminal controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package term_pkg;

    localparam int X_W    = 6;
    localparam int Y_W    = 5;
    localparam int ADDR_W = X_W + Y_W;

    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_EXEC        = 3'd1,
        ST_SCROLL_REQ  = 3'd2,
        ST_SCROLL_WAIT = 3'd3,
        ST_CLEAR       = 3'd4
    } term_state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

`default_nettype wire

// File: rtl/term_ctrl_vram_mux.sv
// ============================================================================
// Module   : vram_mux
// Brief    : Selects between controller and scroll-engine VRAM requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_mux
    import term_pkg::*;
(
    input  logic              i_sel_scr,
    input  logic [ADDR_W-1:0] i_ctl_addr,
    input  logic [7:0]        i_ctl_din,
    input  logic              i_ctl_ce,
    input  logic              i_ctl_w,
    input  logic [ADDR_W-1:0] i_scr_addr,
    input  logic [7:0]        i_scr_din,
    input  logic              i_scr_ce,
    input  logic              i_scr_w,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_din,
    output logic              o_ce,
    output logic              o_w
);

    assign o_addr = i_sel_scr ? i_scr_addr : i_ctl_addr;
    assign o_din  = i_sel_scr ? i_scr_din  : i_ctl_din;
    assign o_ce   = i_sel_scr ? i_scr_ce   : i_ctl_ce;
    assign o_w    = i_sel_scr ? i_scr_w    : i_ctl_w;

endmodule

`default_nettype wire

// File: rtl/term_ctrl.sv
// ============================================================================
// Module   : term_ctrl
// Brief    : Byte-stream text terminal: cursor handling, scroll hand-off, row clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module term_ctrl
    import term_pkg::*;
#(
    parameter int COLS = 60,
    parameter int ROWS = 17
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [7:0]        o_vram_din,
    output logic              o_vram_ce,
    output logic              o_vram_w,
    input  logic [ADDR_W-1:0] i_scr_vram_addr,
    input  logic [7:0]        i_scr_vram_din,
    input  logic              i_scr_vram_ce,
    input  logic              i_scr_vram_w,
    output logic              o_scroll_start,
    input  logic              i_scroll_running,
    output logic [X_W-1:0]    o_cursor_x,
    output logic [Y_W-1:0]    o_cursor_y,
    output logic              o_busy
);

    localparam logic [X_W-1:0] c_last_col = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] c_last_row = Y_W'(ROWS - 1);

    term_state_e       r_state, w_next_state;
    logic [X_W-1:0]    r_x, w_next_x;
    logic [Y_W-1:0]    r_y, w_next_y;
    logic [X_W-1:0]    r_col, w_next_col;
    logic              r_seen, w_next_seen;
    logic [7:0]        r_data;
    logic              r_ready;
    logic              w_newline;
    logic              w_accept;
    logic [ADDR_W-1:0] w_ctl_addr;
    logic [7:0]        w_ctl_din;
    logic              w_ctl_ce;
    logic              w_ctl_w;

    assign w_accept = (r_state == ST_IDLE) && i_valid && r_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_col   <= '0;
            r_seen  <= 1'b0;
            r_data  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_x     <= w_next_x;
            r_y     <= w_next_y;
            r_col   <= w_next_col;
            r_seen  <= w_next_seen;
            r_ready <= (w_next_state == ST_IDLE);
            if (w_accept) begin
                r_data <= i_data;
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_x       = r_x;
        w_next_y       = r_y;
        w_next_col     = r_col;
        w_next_seen    = r_seen;
        w_newline      = 1'b0;
        w_ctl_addr     = '0;
        w_ctl_din      = '0;
        w_ctl_ce       = 1'b0;
        w_ctl_w        = 1'b0;
        o_scroll_start = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_next_state = ST_IDLE;
                if (is_printable(r_data)) begin
                    w_ctl_ce   = 1'b1;
                    w_ctl_w    = 1'b1;
                    w_ctl_addr = {r_y, r_x};
                    w_ctl_din  = r_data;
                    if (r_x == c_last_col) begin
                        w_next_x  = '0;
                        w_newline = 1'b1;
                    end else begin
                        w_next_x = r_x + 1'b1;
                    end
                end else if (r_data == CHR_CR) begin
                    w_next_x = '0;
                end else if (r_data == CHR_LF) begin
                    w_newline = 1'b1;
                end else if (r_data == CHR_BS) begin
                    if (r_x != '0) begin
                        w_next_x = r_x - 1'b1;
                    end
                end
                // Bottom row never moves: the scroll engine shifts the text instead.
                if (w_newline) begin
                    if (r_y == c_last_row) begin
                        w_next_state = ST_SCROLL_REQ;
                    end else begin
                        w_next_y = r_y + 1'b1;
                    end
                end
            end

            ST_SCROLL_REQ: begin
                o_scroll_start = 1'b1;
                w_next_seen    = 1'b0;
                w_next_state   = ST_SCROLL_WAIT;
            end

            ST_SCROLL_WAIT: begin
                // Wait for the engine to have started before accepting its idle level.
                if (i_scroll_running) begin
                    w_next_seen = 1'b1;
                end else if (r_seen) begin
                    w_next_seen  = 1'b0;
                    w_next_col   = '0;
                    w_next_state = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                w_ctl_ce   = 1'b1;
                w_ctl_w    = 1'b1;
                w_ctl_addr = {c_last_row, r_col};
                w_ctl_din  = CHR_SPACE;
                if (r_col == c_last_col) begin
                    w_next_col   = '0;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_col = r_col + 1'b1;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    vram_mux u_vram_mux (
        .i_sel_scr  (r_state == ST_SCROLL_WAIT),
        .i_ctl_addr (w_ctl_addr),
        .i_ctl_din  (w_ctl_din),
        .i_ctl_ce   (w_ctl_ce),
        .i_ctl_w    (w_ctl_w),
        .i_scr_addr (i_scr_vram_addr),
        .i_scr_din  (i_scr_vram_din),
        .i_scr_ce   (i_scr_vram_ce),
        .i_scr_w    (i_scr_vram_w),
        .o_addr     (o_vram_addr),
        .o_din      (o_vram_din),
        .o_ce       (o_vram_ce),
        .o_w        (o_vram_w)
    );

    assign o_ready    = r_ready;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_cursor_x = r_x;
    assign o_cursor_y = r_y;

endmodule

`default_nettype wire

// File: tb/tb_term_ctrl.sv
// ============================================================================
// Module   : tb_term_ctrl
// Brief    : Self-checking bench for term_ctrl against a cursor/VRAM-write model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_term_ctrl;
    import term_pkg::*;

    localparam int COLS = 60;
    localparam int ROWS = 17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        i_data;
    logic              i_valid;
    logic              o_ready;
    logic [ADDR_W-1:0] o_vram_addr;
    logic [7:0]        o_vram_din;
    logic              o_vram_ce;
    logic              o_vram_w;
    logic [ADDR_W-1:0] scr_addr;
    logic [7:0]        scr_din;
    logic              scr_ce;
    logic              scr_w;
    logic              o_scroll_start;
    logic              scr_running;
    logic [X_W-1:0]    o_cursor_x;
    logic [Y_W-1:0]    o_cursor_y;
    logic              o_busy;

    always #5 clk = ~clk;

    term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_data           (i_data),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .o_vram_addr      (o_vram_addr),
        .o_vram_din       (o_vram_din),
        .o_vram_ce        (o_vram_ce),
        .o_vram_w         (o_vram_w),
        .i_scr_vram_addr  (scr_addr),
        .i_scr_vram_din   (scr_din),
        .i_scr_vram_ce    (scr_ce),
        .i_scr_vram_w     (scr_w),
        .o_scroll_start   (o_scroll_start),
        .i_scroll_running (scr_running),
        .o_cursor_x       (o_cursor_x),
        .o_cursor_y       (o_cursor_y),
        .o_busy           (o_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: cursor position and the ordered list of controller writes.
    int mx = 0;
    int my = 0;
    int exp_addr_q[$];
    int exp_din_q[$];
    int exp_scrolls = 0;
    int n_pulses = 0;

    function automatic void model_newline();
        if (my < ROWS - 1) begin
            my++;
        end else begin
            exp_scrolls++;
            for (int c = 0; c < COLS; c++) begin
                exp_addr_q.push_back((ROWS - 1) * 64 + c);
                exp_din_q.push_back(32);
            end
        end
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_addr_q.push_back(my * 64 + mx);
            exp_din_q.push_back(int'(b));
            if (mx < COLS - 1) begin
                mx++;
            end else begin
                mx = 0;
                model_newline();
            end
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h0A) begin
            model_newline();
        end else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end
    endfunction

    function automatic void model_reset();
        mx = 0;
        my = 0;
        exp_addr_q.delete();
        exp_din_q.delete();
    endfunction

    // Every controller-side VRAM access must match the next expected write.
    always @(negedge clk) begin
        if (o_vram_ce && !scr_running) begin
            chk_eq("wr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            chk_eq("wr_we", 32'(o_vram_w), 32'd1);
            if (exp_addr_q.size() != 0) begin
                chk_eq("wr_addr", 32'(o_vram_addr), 32'(exp_addr_q.pop_front()));
                chk_eq("wr_din", 32'(o_vram_din), 32'(exp_din_q.pop_front()));
            end
        end
    end

    // Scroll engine: random start delay and duration, random requests while running.
    initial begin
        int dur;
        scr_running = 1'b0;
        scr_ce      = 1'b0;
        scr_w       = 1'b0;
        scr_addr    = '0;
        scr_din     = '0;
        forever begin
            @(negedge clk);
            if (o_scroll_start) begin
                n_pulses++;
                @(negedge clk);
                chk_eq("scroll_pulse_width", 32'(o_scroll_start), 32'd0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                #2;
                dur         = $urandom_range(1, 8);
                scr_running = 1'b1;
                scr_ce      = 1'b1;
                scr_w       = 1'b1;
                scr_addr    = ADDR_W'($urandom);
                scr_din     = 8'($urandom);
                repeat (dur) begin
                    @(negedge clk);
                    chk_eq("mirror_addr", 32'(o_vram_addr), 32'(scr_addr));
                    chk_eq("mirror_din", 32'(o_vram_din), 32'(scr_din));
                    chk_eq("mirror_ce", 32'(o_vram_ce), 32'(scr_ce));
                    chk_eq("mirror_w", 32'(o_vram_w), 32'(scr_w));
                    #2;
                    scr_addr = ADDR_W'($urandom);
                    scr_din  = 8'($urandom);
                end
                scr_running = 1'b0;
                scr_ce      = 1'b0;
                scr_w       = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!o_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) chk_eq("ready_timeout", 32'(o_ready), 32'd1);
    endtask

    // Offer one byte; with hold, i_valid stays high carrying junk while not ready.
    task automatic send(input logic [7:0] b, input bit hold);
        int guard = 0;
        @(negedge clk);
        while (!o_ready && guard < 2000) begin
            i_valid = hold;
            i_data  = 8'($urandom);
            @(negedge clk);
            guard++;
        end
        if (!o_ready) begin
            chk_eq("ready_timeout", 32'(o_ready), 32'd1);
            return;
        end
        chk_eq("cursor_x", 32'(o_cursor_x), 32'(mx));
        chk_eq("cursor_y", 32'(o_cursor_y), 32'(my));
        i_data  = b;
        i_valid = 1'b1;
        @(posedge clk);
        model_apply(b);
        #1;
        if (!hold) i_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_ready"}, 32'(o_ready), 32'd0);
        chk_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk_eq({tag, "_scroll_start"}, 32'(o_scroll_start), 32'd0);
        chk_eq({tag, "_ce"}, 32'(o_vram_ce), 32'd0);
        chk_eq({tag, "_w"}, 32'(o_vram_w), 32'd0);
        chk_eq({tag, "_addr"}, 32'(o_vram_addr), 32'd0);
        chk_eq({tag, "_din"}, 32'(o_vram_din), 32'd0);
        chk_eq({tag, "_cx"}, 32'(o_cursor_x), 32'd0);
        chk_eq({tag, "_cy"}, 32'(o_cursor_y), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        int pulses_before;
        int kind;
        logic [7:0] b;

        i_valid = 1'b0;
        i_data  = '0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        chk_reset_outputs("rst");

        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_eq("ready_before_edge", 32'(o_ready), 32'd0);
        @(negedge clk);
        chk_eq("ready_after_rst", 32'(o_ready), 32'd1);

        // 'A' from reset: write at N+1, ready again at N+2.
        i_data  = 8'h41;
        i_valid = 1'b1;
        @(posedge clk);
        model_apply(8'h41);
        #1 i_valid = 1'b0;
        @(negedge clk);
        chk_eq("a_ready_n1", 32'(o_ready), 32'd0);
        chk_eq("a_busy_n1", 32'(o_busy), 32'd1);
        chk_eq("a_ce_n1", 32'(o_vram_ce), 32'd1);
        @(negedge clk);
        chk_eq("a_ready_n2", 32'(o_ready), 32'd1);
        chk_eq("a_cx", 32'(o_cursor_x), 32'd1);
        chk_eq("a_cy", 32'(o_cursor_y), 32'd0);

        // Control bytes at (7,2): CR, BS at column 0, ignored byte.
        send(8'h0A, 1'b0);
        send(8'h0A, 1'b0);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(32, 126)), 1'b0);
        send(8'h0D, 1'b0);
        send(8'h08, 1'b0);
        send(8'h07, 1'b0);
        wait_idle();
        chk_eq("ctl_cx", 32'(o_cursor_x), 32'd0);
        chk_eq("ctl_cy", 32'(o_cursor_y), 32'd2);

        // Wrap at the last column without scrolling.
        send(8'h0A, 1'b0);
        for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(32, 126)), 1'b0);
        pulses_before = n_pulses;
        send(8'h5A, 1'b0);
        wait_idle();
        chk_eq("wrap_cx", 32'(o_cursor_x), 32'd0);
        chk_eq("wrap_cy", 32'(o_cursor_y), 32'd4);
        chk_eq("wrap_no_scroll", 32'(n_pulses), 32'(pulses_before));

        // LF on the bottom row: scroll then clear, cursor held at (5,16).
        while (my < ROWS - 1) send(8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)), 1'b0);
        pulses_before = n_pulses;
        send(8'h0A, 1'b0);
        wait_idle();
        chk_eq("scroll_pulses", 32'(n_pulses), 32'(pulses_before + 1));
        chk_eq("scroll_cx", 32'(o_cursor_x), 32'd5);
        chk_eq("scroll_cy", 32'(o_cursor_y), 32'd16);
        chk_eq("scroll_drained", 32'(exp_addr_q.size()), 32'd0);

        // Valid held with junk bytes through scroll and clear.
        send(8'h0A, 1'b1);
        for (int i = 0; i < 3; i++) send(8'($urandom_range(32, 126)), 1'b1);
        send(8'h0A, 1'b1);
        i_valid = 1'b0;
        wait_idle();
        chk_eq("hold_drained", 32'(exp_addr_q.size()), 32'd0);

        // Reset in the middle of the row clear.
        send(8'h0A, 1'b0);
        guard = 0;
        @(negedge clk);
        while (!(o_vram_ce && !scr_running && o_vram_addr == ADDR_W'((ROWS - 1) * 64 + 30))
               && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk_eq("clear_col30_reached", 32'(guard < 2000), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("midclr");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk_eq("midclr_ready_before_edge", 32'(o_ready), 32'd0);
        @(negedge clk);
        chk_eq("midclr_ready_after", 32'(o_ready), 32'd1);
        chk_eq("midclr_no_pending", 32'(exp_addr_q.size()), 32'd0);

        // Randomised byte stream.
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4)      b = 8'($urandom_range(32, 126));
            else if (kind <= 6) b = 8'h0A;
            else if (kind == 7) b = 8'h0D;
            else if (kind == 8) b = 8'h08;
            else                b = 8'($urandom_range(128, 255));
            send(b, 1'($urandom_range(0, 1)));
        end
        i_valid = 1'b0;
        wait_idle();
        chk_eq("final_cx", 32'(o_cursor_x), 32'(mx));
        chk_eq("final_cy", 32'(o_cursor_y), 32'(my));
        chk_eq("final_pending", 32'(exp_addr_q.size()), 32'd0);
        chk_eq("final_scrolls", 32'(n_pulses), 32'(exp_scrolls));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
